spi_sd_cmd_receiver: RTL and testbench
======================================

Name: spi_sd_cmd_receiver

Overview:
- SPI-slave front end for an SD-card-style command interface, with a command-decode LED debugger.
- Oversamples SPI_CLK/SPI_DI on the system clock and deframes 48-bit command frames (start, transmit, 6-bit command, 32-bit argument, 7-bit CRC, end bit).
- Exposes the received command, its argument and status flags, and latches one sticky LED per recognised command (CMD0, CMD8, CMD16, CMD55, ACMD41).
- Sits between the board SPI pins and the SD-emulation core logic.

Parameters:
- none

Ports:
- clock  in  1  system clock; must be at least 2x SPI_CLK; each SPI_CLK level lasts at least 1 clock cycle.
- reset  in  1  asynchronous, active-low reset.
- spi_clk  in  1  SPI clock, mode 0.
- spi_cs  in  1  chip select, active low.
- spi_di  in  1  serial data from host (MOSI).
- spi_do  out  1  serial data to host (MISO).
- do_in  in  1  core data to drive onto spi_do.
- di_out  out  1  registered spi_di for the core.
- command_read_finished  out  1  6 command bits received.
- argument_read_finished  out  1  32 argument bits received.
- read_success  out  1  frame completed with end bit = 1.
- command  out  6  received command index.
- command_argument  out  32  received argument.
- dbg_state  out  3  FSM state encoding.
- dbg_counter  out  3  bit counter, low 3 bits.
- dbg_buffer  out  8  last 8 sampled bits.
- led_cmd0  out  1  sticky flag: CMD0 seen.
- led_cmd8  out  1  sticky flag: CMD8 seen.
- led_acmd41  out  1  sticky flag: ACMD41 seen.
- led_cmd16  out  1  sticky flag: CMD16 seen.
- led_cmd55  out  1  sticky flag: CMD55 seen.

Behaviour:
- Sampling
  - spi_clk, spi_di and spi_cs are registered one stage (clk_q, di_q, cs_q); prev_clk_q = clk_q delayed by one more clock.
  - Rising edge = clk_q & ~prev_clk_q; on that cycle di_q is the sampled bit.
  - di_out = di_q.
  - spi_do = do_in when cs_q = 0, else 1.
- FSM states, with dbg_state values:
  - IDLE = 0: on a sampled bit 0, go to TXBIT.
  - TXBIT = 1: sampled 1 goes to CMD, counter cleared; sampled 0 goes to IDLE.
  - CMD = 2: shift bits in LSB first (first bit is command[0]). After the 6th bit, set command_read_finished, go to ARG.
  - ARG = 3: shift LSB first (first bit is argument[0]). After the 32nd bit, set argument_read_finished, go to CRC.
  - CRC = 4: 7 bits are received and ignored; no CRC check. Then go to END.
  - END = 5: sampled 1 sets read_success; sampled 0 leaves it 0. Either way, go to IDLE.
- Counter and buffer
  - Internal bit counter is 6 bits; dbg_counter shows its low 3 bits.
  - dbg_buffer shifts in every sampled bit in every state, newest bit at bit 0.
- Flags
  - command_read_finished, argument_read_finished and read_success are levels.
  - All three clear when the start bit of the next frame is detected (IDLE leaves on a 0).
  - command and command_argument hold their last values until overwritten bit by bit.
- spi_cs = 1 at any time: FSM goes to IDLE and the counter clears; flags and data are kept.
- Reset (async, low): all registers 0, buffer 0, all flags and LEDs 0, state IDLE. Reset mid-frame aborts the frame.
- LED debugger
  - Acts on the rising edge of read_success, detected by a registered copy.
  - command 0 sets led_cmd0.
  - command 8 sets led_cmd8.
  - command 16 sets led_cmd16.
  - command 55 sets led_cmd55 and sets an app_pending flag.
  - command 41 with app_pending = 1 sets led_acmd41.
  - Every completed command other than 55 clears app_pending; a second consecutive CMD55 keeps it set.
  - CMD41 without a preceding CMD55 sets no LED.
  - LEDs are sticky until reset.
  - A frame with a bad end bit has no effect.

Test Plan:
- Reset, then 8 idle clocks with di = 1, then a CMD0 frame with argument 1218 -> command = 0, command_argument = 1218, all three flags = 1, led_cmd0 = 1, other LEDs 0.
- CMD8 frame, then CMD16 frame -> led_cmd8 = 1 and led_cmd16 = 1; flags clear at each start bit; dbg_state returns to 0 after each end bit.
- CMD55, CMD55, then CMD16 -> led_cmd55 = 1, led_acmd41 = 0; app_pending is cleared by the CMD16.
- CMD55 immediately followed by CMD41 -> led_acmd41 = 1; CMD41 alone after reset -> led_acmd41 = 0.
- Frame with end bit 0 -> command_read_finished = 1, argument_read_finished = 1, read_success = 0, no LED change.
- spi_cs raised during ARG, or reset asserted mid-frame -> dbg_state = 0, dbg_counter = 0; after reset, all outputs are 0.

Source files
------------

// File: rtl/spi_sd_cmd_receiver.sv
// SPI-slave (mode 0) front end that deframes 48-bit SD-style command frames
// and latches one sticky LED per recognised command.
module spi_sd_cmd_receiver (
    input  logic        clock,
    input  logic        reset,
    input  logic        spi_clk,
    input  logic        spi_cs,
    input  logic        spi_di,
    output logic        spi_do,
    input  logic        do_in,
    output logic        di_out,
    output logic        command_read_finished,
    output logic        argument_read_finished,
    output logic        read_success,
    output logic [5:0]  command,
    output logic [31:0] command_argument,
    output logic [2:0]  dbg_state,
    output logic [2:0]  dbg_counter,
    output logic [7:0]  dbg_buffer,
    output logic        led_cmd0,
    output logic        led_cmd8,
    output logic        led_acmd41,
    output logic        led_cmd16,
    output logic        led_cmd55
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_TXBIT = 3'd1;
    localparam logic [2:0] ST_CMD   = 3'd2;
    localparam logic [2:0] ST_ARG   = 3'd3;
    localparam logic [2:0] ST_CRC   = 3'd4;
    localparam logic [2:0] ST_END   = 3'd5;

    logic        clk_q, di_q, cs_q, prev_clk_q;
    logic [2:0]  state_q, state_d;
    logic [5:0]  counter_q, counter_d;
    logic [7:0]  buffer_q, buffer_d;
    logic [5:0]  command_q, command_d;
    logic [31:0] argument_q, argument_d;
    logic        cmd_fin_q, cmd_fin_d;
    logic        arg_fin_q, arg_fin_d;
    logic        success_q, success_d;
    logic        success_prev_q, success_prev_d;
    logic        app_pending_q, app_pending_d;
    logic        led0_q, led0_d, led8_q, led8_d, led16_q, led16_d;
    logic        led55_q, led55_d, led41_q, led41_d;
    logic        rise;

    assign rise = clk_q & ~prev_clk_q;

    always_comb begin
        state_d        = state_q;
        counter_d      = counter_q;
        buffer_d       = buffer_q;
        command_d      = command_q;
        argument_d     = argument_q;
        cmd_fin_d      = cmd_fin_q;
        arg_fin_d      = arg_fin_q;
        success_d      = success_q;
        success_prev_d = success_q;
        app_pending_d  = app_pending_q;
        led0_d         = led0_q;
        led8_d         = led8_q;
        led16_d        = led16_q;
        led55_d        = led55_q;
        led41_d        = led41_q;

        if (rise) begin
            buffer_d = {buffer_q[6:0], di_q};
        end

        // Deselect aborts the frame but keeps whatever was already captured.
        if (cs_q) begin
            state_d   = ST_IDLE;
            counter_d = '0;
        end else if (rise) begin
            case (state_q)
                ST_IDLE: begin
                    if (!di_q) begin
                        state_d   = ST_TXBIT;
                        cmd_fin_d = 1'b0;
                        arg_fin_d = 1'b0;
                        success_d = 1'b0;
                    end
                end
                ST_TXBIT: begin
                    if (di_q) begin
                        state_d   = ST_CMD;
                        counter_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    command_d[counter_q[2:0]] = di_q;
                    if (counter_q == 6'd5) begin
                        cmd_fin_d = 1'b1;
                        state_d   = ST_ARG;
                        counter_d = '0;
                    end else begin
                        counter_d = counter_q + 6'd1;
                    end
                end
                ST_ARG: begin
                    argument_d[counter_q[4:0]] = di_q;
                    if (counter_q == 6'd31) begin
                        arg_fin_d = 1'b1;
                        state_d   = ST_CRC;
                        counter_d = '0;
                    end else begin
                        counter_d = counter_q + 6'd1;
                    end
                end
                ST_CRC: begin
                    if (counter_q == 6'd6) begin
                        state_d   = ST_END;
                        counter_d = '0;
                    end else begin
                        counter_d = counter_q + 6'd1;
                    end
                end
                ST_END: begin
                    success_d = di_q;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Command is stable here: it only changes after the next start bit.
        if (success_q && !success_prev_q) begin
            app_pending_d = 1'b0;
            case (command_q)
                6'd0:  led0_d  = 1'b1;
                6'd8:  led8_d  = 1'b1;
                6'd16: led16_d = 1'b1;
                6'd55: begin
                    led55_d       = 1'b1;
                    app_pending_d = 1'b1;
                end
                6'd41: begin
                    if (app_pending_q) begin
                        led41_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_q          <= 1'b0;
            di_q           <= 1'b0;
            cs_q           <= 1'b0;
            prev_clk_q     <= 1'b0;
            state_q        <= ST_IDLE;
            counter_q      <= '0;
            buffer_q       <= '0;
            command_q      <= '0;
            argument_q     <= '0;
            cmd_fin_q      <= 1'b0;
            arg_fin_q      <= 1'b0;
            success_q      <= 1'b0;
            success_prev_q <= 1'b0;
            app_pending_q  <= 1'b0;
            led0_q         <= 1'b0;
            led8_q         <= 1'b0;
            led16_q        <= 1'b0;
            led55_q        <= 1'b0;
            led41_q        <= 1'b0;
        end else begin
            clk_q          <= spi_clk;
            di_q           <= spi_di;
            cs_q           <= spi_cs;
            prev_clk_q     <= clk_q;
            state_q        <= state_d;
            counter_q      <= counter_d;
            buffer_q       <= buffer_d;
            command_q      <= command_d;
            argument_q     <= argument_d;
            cmd_fin_q      <= cmd_fin_d;
            arg_fin_q      <= arg_fin_d;
            success_q      <= success_d;
            success_prev_q <= success_prev_d;
            app_pending_q  <= app_pending_d;
            led0_q         <= led0_d;
            led8_q         <= led8_d;
            led16_q        <= led16_d;
            led55_q        <= led55_d;
            led41_q        <= led41_d;
        end
    end

    assign spi_do                 = cs_q ? 1'b1 : do_in;
    assign di_out                 = di_q;
    assign command_read_finished  = cmd_fin_q;
    assign argument_read_finished = arg_fin_q;
    assign read_success           = success_q;
    assign command                = command_q;
    assign command_argument       = argument_q;
    assign dbg_state              = state_q;
    assign dbg_counter            = counter_q[2:0];
    assign dbg_buffer             = buffer_q;
    assign led_cmd0               = led0_q;
    assign led_cmd8               = led8_q;
    assign led_cmd16              = led16_q;
    assign led_cmd55              = led55_q;
    assign led_acmd41             = led41_q;

endmodule

// File: tb/tb_spi_sd_cmd_receiver.sv
// Directed bench for spi_sd_cmd_receiver: frames are bit-banged LSB first on
// the SPI pins and outputs are compared against hand-computed values.
module tb_spi_sd_cmd_receiver;

    logic        clock;
    logic        reset;
    logic        spi_clk, spi_cs, spi_di, spi_do, do_in, di_out;
    logic        command_read_finished, argument_read_finished, read_success;
    logic [5:0]  command;
    logic [31:0] command_argument;
    logic [2:0]  dbg_state, dbg_counter;
    logic [7:0]  dbg_buffer;
    logic        led_cmd0, led_cmd8, led_acmd41, led_cmd16, led_cmd55;

    int total = 0;
    int bad   = 0;

    spi_sd_cmd_receiver dut (
        .clock                  (clock),
        .reset                  (reset),
        .spi_clk                (spi_clk),
        .spi_cs                 (spi_cs),
        .spi_di                 (spi_di),
        .spi_do                 (spi_do),
        .do_in                  (do_in),
        .di_out                 (di_out),
        .command_read_finished  (command_read_finished),
        .argument_read_finished (argument_read_finished),
        .read_success           (read_success),
        .command                (command),
        .command_argument       (command_argument),
        .dbg_state              (dbg_state),
        .dbg_counter            (dbg_counter),
        .dbg_buffer             (dbg_buffer),
        .led_cmd0               (led_cmd0),
        .led_cmd8               (led_cmd8),
        .led_acmd41             (led_acmd41),
        .led_cmd16              (led_cmd16),
        .led_cmd55              (led_cmd55)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packed views: leds = {acmd41, cmd55, cmd16, cmd8, cmd0}, flags = {cmd, arg, success}.
    wire [4:0] leds  = {led_acmd41, led_cmd55, led_cmd16, led_cmd8, led_cmd0};
    wire [2:0] flags = {command_read_finished, argument_read_finished, read_success};

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        spi_di  = b;
        spi_clk = 1'b0;
        tick(2);
        spi_clk = 1'b1;
        tick(2);
        spi_clk = 1'b0;
    endtask

    task automatic send_body(input logic [5:0] c, input logic [31:0] a, input logic [6:0] crc,
                             input logic endb);
        send_bit(1'b1);
        for (int i = 0; i < 6; i++) send_bit(c[i]);
        for (int i = 0; i < 32; i++) send_bit(a[i]);
        for (int i = 0; i < 7; i++) send_bit(crc[i]);
        send_bit(endb);
        spi_di = 1'b1;
        tick(3);
    endtask

    task automatic send_frame(input logic [5:0] c, input logic [31:0] a, input logic endb);
        send_bit(1'b0);
        send_body(c, a, 7'h53, endb);
    endtask

    task automatic pulse_reset();
        spi_di = 1'b1;
        reset  = 1'b0;
        tick(2);
        reset  = 1'b1;
        tick(2);
    endtask

    initial begin
        logic [31:0] partial_arg;
        reset   = 1'b0;
        spi_clk = 1'b0;
        spi_cs  = 1'b1;
        spi_di  = 1'b1;
        do_in   = 1'b0;
        tick(3);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_counter", 32'(dbg_counter), 32'd0);
        chk("rst_buffer", 32'(dbg_buffer), 32'd0);
        chk("rst_command", 32'(command), 32'd0);
        chk("rst_arg", command_argument, 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_di_out", 32'(di_out), 32'd0);
        chk("rst_spi_do", 32'(spi_do), 32'd0);

        reset = 1'b1;
        tick(2);
        chk("cs_high_spi_do", 32'(spi_do), 32'd1);
        chk("di_out_follow", 32'(di_out), 32'd1);
        spi_cs = 1'b0;
        do_in  = 1'b1;
        tick(8);
        chk("spi_do_drive1", 32'(spi_do), 32'd1);
        do_in = 1'b0;
        tick(1);
        chk("spi_do_drive0", 32'(spi_do), 32'd0);

        // CMD0, argument 1218, CRC 0x53, end bit 1
        send_frame(6'd0, 32'd1218, 1'b1);
        chk("cmd0_command", 32'(command), 32'd0);
        chk("cmd0_arg", command_argument, 32'd1218);
        chk("cmd0_flags", 32'(flags), 32'b111);
        chk("cmd0_leds", 32'(leds), 32'b00001);
        chk("cmd0_state", 32'(dbg_state), 32'd0);
        chk("cmd0_counter", 32'(dbg_counter), 32'd0);
        chk("cmd0_buffer", 32'(dbg_buffer), 32'hCB);

        send_bit(1'b0);
        chk("cmd8_start_state", 32'(dbg_state), 32'd1);
        chk("cmd8_start_flags", 32'(flags), 32'b000);
        send_body(6'd8, 32'h000001AA, 7'h53, 1'b1);
        chk("cmd8_command", 32'(command), 32'd8);
        chk("cmd8_arg", command_argument, 32'h1AA);
        chk("cmd8_leds", 32'(leds), 32'b00011);
        chk("cmd8_state", 32'(dbg_state), 32'd0);

        send_bit(1'b0);
        chk("cmd16_start_flags", 32'(flags), 32'b000);
        send_body(6'd16, 32'd512, 7'h53, 1'b1);
        chk("cmd16_command", 32'(command), 32'd16);
        chk("cmd16_leds", 32'(leds), 32'b00111);
        chk("cmd16_state", 32'(dbg_state), 32'd0);

        pulse_reset();
        chk("rst2_leds", 32'(leds), 32'd0);
        send_frame(6'd41, 32'h40000000, 1'b1);
        chk("lone41_command", 32'(command), 32'd41);
        chk("lone41_leds", 32'(leds), 32'b00000);
        send_frame(6'd55, 32'd0, 1'b1);
        send_frame(6'd55, 32'd0, 1'b1);
        send_frame(6'd16, 32'd512, 1'b1);
        chk("55_55_16_leds", 32'(leds), 32'b01100);
        send_frame(6'd41, 32'd0, 1'b1);
        chk("41_after_16_leds", 32'(leds), 32'b01100);
        send_frame(6'd55, 32'd0, 1'b1);
        send_frame(6'd41, 32'd0, 1'b1);
        chk("acmd41_leds", 32'(leds), 32'b11100);

        pulse_reset();
        send_frame(6'd0, 32'hDEADBEEF, 1'b0);
        chk("badend_flags", 32'(flags), 32'b110);
        chk("badend_arg", command_argument, 32'hDEADBEEF);
        chk("badend_leds", 32'(leds), 32'b00000);
        send_frame(6'd55, 32'd0, 1'b0);
        send_frame(6'd41, 32'd0, 1'b1);
        chk("bad55_then41_leds", 32'(leds), 32'b00000);

        // Deselect in the middle of the argument field
        partial_arg = 32'h15;
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 6; i++) send_bit(i == 0 || i == 4);
        for (int i = 0; i < 5; i++) send_bit(partial_arg[i]);
        chk("midarg_state", 32'(dbg_state), 32'd3);
        chk("midarg_counter", 32'(dbg_counter), 32'd5);
        spi_cs = 1'b1;
        tick(3);
        chk("csabort_state", 32'(dbg_state), 32'd0);
        chk("csabort_counter", 32'(dbg_counter), 32'd0);
        chk("csabort_command", 32'(command), 32'd17);
        chk("csabort_flags", 32'(flags), 32'b100);
        spi_cs = 1'b0;
        tick(2);

        // Reset in the middle of the CRC field
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 6; i++) send_bit(i == 3);
        for (int i = 0; i < 32; i++) send_bit(1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        chk("midcrc_state", 32'(dbg_state), 32'd4);
        chk("midcrc_counter", 32'(dbg_counter), 32'd3);
        spi_di = 1'b1;
        reset  = 1'b0;
        tick(1);
        chk("midrst_state", 32'(dbg_state), 32'd0);
        chk("midrst_counter", 32'(dbg_counter), 32'd0);
        chk("midrst_command", 32'(command), 32'd0);
        chk("midrst_arg", command_argument, 32'd0);
        chk("midrst_flags", 32'(flags), 32'd0);
        chk("midrst_buffer", 32'(dbg_buffer), 32'd0);
        reset = 1'b1;
        tick(2);
        send_frame(6'd8, 32'h000001AA, 1'b1);
        chk("recover_leds", 32'(leds), 32'b00010);
        chk("recover_arg", command_argument, 32'h1AA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
